// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a registered byte FIFO on a valid/ready stream.
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module uart_rx_monitor #(
  parameter int unsigned ClksPerBit = 16,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic                         busy_o,
  output logic [$clog2(FifoDepth):0]   fifo_count_o
);

  localparam int unsigned CntW   = $clog2(ClksPerBit);
  localparam int unsigned AddrW  = $clog2(FifoDepth);
  localparam int unsigned CountW = AddrW + 1;
  localparam logic [CntW-1:0]   BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]   HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CountW-1:0] FullCnt  = CountW'(FifoDepth);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_n;
  logic            rx_meta, rx_s;
  logic [1:0]      primed_q;
  logic [CntW-1:0] cnt_q, cnt_n;
  logic [2:0]      idx_q, idx_n;
  logic [7:0]      shift_q, shift_n;
  logic            push_c, ferr_c;
  logic            push_q;
  logic [7:0]      byte_q;

  // Synchronizer; primed_q marks when rx_s carries the real pin value after reset,
  // so a line held low across reset is not mistaken for idle-high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      primed_q <= 2'b00;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      primed_q <= {primed_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_HIGH;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      byte_q      <= '0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      idx_q       <= idx_n;
      shift_q     <= shift_n;
      push_q      <= push_c;
      if (push_c) byte_q <= shift_q;
      frame_err_o <= ferr_c;
      busy_o      <= (state_n == START) || (state_n == DATA) || (state_n == STOP);
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    unique case (state_q)
      WAIT_HIGH: if (primed_q[1] && rx_s) state_n = IDLE;
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HalfLast;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CntW'(1);
        end else if (!rx_s) begin
          state_n = DATA;
          cnt_n   = BitLast;
          idx_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CntW'(1);
        end else begin
          shift_n[idx_q] = rx_s;
          cnt_n          = BitLast;
          if (idx_q == 3'd7) state_n = STOP;
          else idx_n = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CntW'(1);
        end else if (rx_s) begin
          push_c  = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_c  = 1'b1;
          state_n = WAIT_HIGH;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  logic [7:0]        mem [FifoDepth];
  logic [AddrW-1:0]  wr_ptr, rd_ptr, rd_n;
  logic [CountW-1:0] count_n, remain_c;
  logic              pop_c, full_c, push_ok_c;

  assign pop_c     = valid_o & ready_i;
  assign full_c    = (fifo_count_o == FullCnt);
  assign push_ok_c = push_q & (!full_c | pop_c);
  assign remain_c  = fifo_count_o - CountW'(pop_c);
  assign count_n   = remain_c + CountW'(push_ok_c);
  assign rd_n      = rd_ptr + AddrW'(pop_c);

  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem[wr_ptr] <= byte_q;
  end

  // Head register: a push into an otherwise-empty FIFO becomes the head directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AddrW'(1);
      rd_ptr       <= rd_n;
      fifo_count_o <= count_n;
      valid_o      <= (count_n != '0);
      overflow_o   <= push_q & full_c & !pop_c;
      if (push_ok_c && (remain_c == '0)) data_o <= byte_q;
      else if (pop_c && (remain_c != '0)) data_o <= mem[rd_n];
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: directed UART frames, expected bytes queued
// at stimulus time and popped by an independent stream monitor.
module tb_uart_rx_monitor;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovf, busy;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  int ferr_cycles = 0;
  int ovf_cycles = 0;
  logic [7:0] exp_q[$];

  uart_rx_monitor #(.ClksPerBit(Cpb), .FifoDepth(Depth)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx),
    .data_o(data), .valid_o(valid), .ready_i(ready),
    .frame_err_o(ferr), .overflow_o(ovf), .busy_o(busy),
    .fifo_count_o(count)
  );

  always #5 clk = ~clk;

  // Stream monitor and pulse counters
  always @(negedge clk) begin
    if (ferr) ferr_cycles++;
    if (ovf) ovf_cycles++;
    if (valid && ready && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL stream_byte: got %02h expected %02h", data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    cycles(Cpb);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cycles(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    cycles(3);
  endtask

  task automatic clear_counts();
    ferr_cycles = 0;
    ovf_cycles  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cycles(4);
    sample_point();
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(6);

    // 1: single byte with consumer ready
    clear_counts();
    ready = 1'b1;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    drive_bit(1'b1);
    wait_drain("t1_drain");
    sample_point();
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_valid", 32'(valid), 32'd0);
    check("t1_ferr", 32'(ferr_cycles), 32'd0);
    check("t1_ovf", 32'(ovf_cycles), 32'd0);

    // 2: back-to-back frames buffered, then drained in order
    cycles(1);
    ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive_bit(1'b1);
    cycles(4);
    sample_point();
    check("t2_count", 32'(count), 32'd3);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_head", 32'(data), 32'hA5);
    cycles(1);
    ready = 1'b1;
    wait_drain("t2_drain");
    sample_point();
    check("t2_count_end", 32'(count), 32'd0);
    check("t2_valid_end", 32'(valid), 32'd0);

    // 3: framing error followed by a long break, then recovery
    cycles(1);
    clear_counts();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    drive_bit(1'b1);
    wait_drain("t3_drain");
    check("t3_ferr", 32'(ferr_cycles), 32'd1);
    check("t3_ovf", 32'(ovf_cycles), 32'd0);

    // 4: one-clock glitch must be rejected
    clear_counts();
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(20);
    sample_point();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_count", 32'(count), 32'd0);
    check("t4_ferr", 32'(ferr_cycles), 32'd0);
    check("t4_ovf", 32'(ovf_cycles), 32'd0);

    // 5: overflow drops the ninth byte
    cycles(1);
    clear_counts();
    ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    drive_bit(1'b1);
    cycles(4);
    sample_point();
    check("t5_count", 32'(count), 32'd8);
    check("t5_ovf", 32'(ovf_cycles), 32'd1);
    check("t5_head", 32'(data), 32'h01);
    cycles(1);
    ready = 1'b1;
    wait_drain("t5_drain");
    sample_point();
    check("t5_count_end", 32'(count), 32'd0);

    // 6: reset mid-frame with the line low across reset release
    cycles(1);
    clear_counts();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx  = 1'b0;
    rst = 1'b1;
    cycles(2);
    sample_point();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    exp_q.push_back(8'h34);
    send_byte(8'h34, 1'b1);
    drive_bit(1'b1);
    wait_drain("t6_drain");
    check("t6_ferr", 32'(ferr_cycles), 32'd0);
    check("t6_ovf", 32'(ovf_cycles), 32'd0);
    sample_point();
    check("t6_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
